// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit. The CPU decoder
// imports op_e from here, so the unit and decode stay in step on encodings.
package mips_muldiv_pkg;

  // Operation encoding driven onto op by the decode stage.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  // Sequencer states: idle, iterate multiply, iterate divide, sign fix-up.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Widest operand the helper functions below are sized for.
  localparam int MAX_WIDTH = 64;

  // LO value written by a divide with a zero divisor: WIDTH ones.
  function automatic logic [MAX_WIDTH-1:0] div0_lo(input int width);
    logic [MAX_WIDTH-1:0] ones;
    ones = '0;
    for (int i = 0; i < width; i++) ones[i] = 1'b1;
    return ones;
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// CPU-facing request/result bundle for the multiply/divide unit.
interface mips_muldiv_unit_if
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             clock_enable;
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // CPU side: issues operations and reads HI/LO.
  modport master (
    output clock_enable, start, op, op_a, op_b,
    input  busy, done, div_by_zero, hi, lo
  );

  // Unit side.
  modport slave (
    input  clock_enable, start, op, op_a, op_b,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mips_muldiv_unit_step.sv
// Combinational iteration kernel: retires UNROLL bits of either an unsigned
// shift-add multiply or a restoring divide on the {upper, lower} pair.
//   multiply: upper = partial product high, lower = multiplier / product low
//   divide:   upper = partial remainder,    lower = dividend / quotient
module muldiv_step #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] upper_in,
  input  logic [WIDTH-1:0] lower_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] upper_out,
  output logic [WIDTH-1:0] lower_out
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sum;
  logic             qbit;

  // Unrolled chain of single-bit multiply or divide steps.
  always_comb begin
    // NOTE: blocking assignments here are deliberate - each unrolled bit
    // must see the value produced by the previous bit in the same cycle.
    upper = upper_in;
    lower = lower_in;
    trial = '0;
    sum   = '0;
    qbit  = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        trial = {upper, lower[WIDTH-1]};
        qbit  = (trial >= {1'b0, operand});
        if (qbit) trial = trial - {1'b0, operand};
        upper = trial[WIDTH-1:0];
        lower = {lower[WIDTH-2:0], qbit};
      end else begin
        sum   = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        upper = sum[WIDTH:1];
        lower = {sum[0], lower[WIDTH-1:1]};
      end
    end
    upper_out = upper;
    lower_out = lower;
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO
// registers. Operands are reduced to magnitudes on accept, iterated for ITER
// cycles, and sign-corrected in a final FIX cycle that writes HI/LO at once.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input logic                clk,
  input logic                reset,
  mips_muldiv_unit_if.slave  bus
);

  localparam int               ITER     = WIDTH / UNROLL;
  localparam int               CNT_W    = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [WIDTH-1:0] DIV0_LO  = WIDTH'(div0_lo(WIDTH));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   upper_q, lower_q, operand_q;
  logic [WIDTH-1:0]   upper_nxt, lower_nxt;
  logic               is_div_q, neg_q, rem_neg_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;
  logic               load, step, fix, wr_hi, wr_lo;

  // Operand preparation for the accept edge.
  logic             signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Sign fix-up of the finished iteration.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, hi_fix, lo_fix;

  muldiv_step #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) u_step (
    .is_div    (is_div_q),
    .upper_in  (upper_q),
    .lower_in  (lower_q),
    .operand   (operand_q),
    .upper_out (upper_nxt),
    .lower_out (lower_nxt)
  );

  // Magnitudes and result signs of the incoming operation.
  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    a_neg     = signed_op & bus.op_a[WIDTH-1];
    b_neg     = signed_op & bus.op_b[WIDTH-1];
    mag_a     = a_neg ? -bus.op_a : bus.op_a;
    mag_b     = b_neg ? -bus.op_b : bus.op_b;
  end

  // Final HI/LO values: negate magnitudes where the result sign demands it.
  // Divide-by-zero leaves |op_a| as the remainder, which re-signs to op_a.
  always_comb begin
    prod_fix = neg_q ? -{upper_q, lower_q} : {upper_q, lower_q};
    quot_fix = neg_q ? -lower_q : lower_q;
    rem_fix  = rem_neg_q ? -upper_q : upper_q;
    if (is_div_q) begin
      hi_fix = rem_fix;
      lo_fix = div0_q ? DIV0_LO : quot_fix;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // FSM state register; reset wins over clock_enable.
  always_ff @(posedge clk) begin
    if (reset)                 state_q <= ST_IDLE;
    else if (bus.clock_enable) state_q <= state_d;
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin load = 1'b1; state_d = ST_MUL; end
            OP_DIV,  OP_DIVU:  begin load = 1'b1; state_d = ST_DIV; end
            OP_MTHI:           wr_hi = 1'b1;
            OP_MTLO:           wr_lo = 1'b1;
            default:           ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration working registers: loaded on accept, advanced each step.
  always_ff @(posedge clk) begin
    // NOTE: these hold no architectural state and are always reloaded on
    // accept before use, so they are deliberately left without a reset.
    if (bus.clock_enable) begin
      if (load) begin
        cnt_q     <= '0;
        upper_q   <= '0;
        lower_q   <= div_op ? mag_a : mag_b;
        operand_q <= div_op ? mag_b : mag_a;
        is_div_q  <= div_op;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div0_q    <= div_op && (bus.op_b == '0);
      end else if (step) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        upper_q <= upper_nxt;
        lower_q <= lower_nxt;
      end
    end
  end

  // Architectural HI/LO and the completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (bus.clock_enable) begin
      done_q <= fix;
      dbz_q  <= fix & is_div_q & div0_q;
      if (fix) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
      if (wr_hi) hi_q <= bus.op_a;
      if (wr_lo) lo_q <= bus.op_a;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: expected HI/LO/div_by_zero are queued
// when an operation is issued and compared when the unit reports done.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;
  exp_t sb_q[$];

  mips_muldiv_unit_if #(.WIDTH(32)) bus1 ();
  mips_muldiv_unit_if #(.WIDTH(32)) bus4 ();

  mips_muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mips_muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour computed with 64-bit host arithmetic.
  function automatic exp_t model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    longint      sa, sb;
    logic [63:0] p;
    r = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_MULT:  begin p = sa * sb;                 r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (op == OP_DIVU) begin
          r.lo = a / b; r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'h0;
        end else begin
          r.lo = 32'(sa / sb); r.hi = 32'(sa % sb);
        end
      end
    endcase
    return r;
  endfunction

  // Drive a one-cycle request; afterwards scramble operands to prove latching.
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus1.start = 1'b1;
    bus1.op    = op;
    bus1.op_a  = a;
    bus1.op_b  = b;
    tick();
    bus1.start = 1'b0;
    bus1.op_a  = $urandom;
    bus1.op_b  = $urandom;
  endtask

  task automatic expect_result(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for done after an accept; optionally hold clock_enable low
  // for stall_len cycles starting stall_at cycles in. Checks latency, busy
  // duration, HI/LO stability while busy, then the scoreboard entry.
  task automatic wait_done(input int exp_lat, input int stall_at, input int stall_len, input string tag);
    int          k;
    int          busy_cnt;
    bit          seen;
    bit          vis_ok;
    logic [31:0] old_hi, old_lo;
    exp_t        e;
    old_hi = bus1.hi; old_lo = bus1.lo;
    k = 0; busy_cnt = 0; seen = 1'b0; vis_ok = 1'b1;
    while (k < 200 && !seen) begin
      if (stall_len > 0 && k == stall_at)             bus1.clock_enable = 1'b0;
      if (stall_len > 0 && k == stall_at + stall_len) bus1.clock_enable = 1'b1;
      if (bus1.busy) busy_cnt++;
      if (bus1.hi !== old_hi || bus1.lo !== old_lo) vis_ok = 1'b0;
      tick();
      k++;
      if (bus1.done) seen = 1'b1;
    end
    bus1.clock_enable = 1'b1;
    check({tag, " done seen"}, seen, 1);
    check({tag, " latency"}, k, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " hi/lo held"}, vis_ok, 1);
    check({tag, " busy at done"}, bus1.busy, 0);
    check({tag, " scoreboard depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " hi"}, bus1.hi, e.hi);
      check({tag, " lo"}, bus1.lo, e.lo);
      check({tag, " div_by_zero"}, bus1.div_by_zero, e.dbz);
    end
  endtask

  initial begin
    exp_t e;
    int   k;
    bit   seen;

    reset = 1'b1;
    bus1.clock_enable = 1'b1; bus1.start = 1'b0; bus1.op = OP_MULTU;
    bus1.op_a = '0; bus1.op_b = '0;
    bus4.clock_enable = 1'b1; bus4.start = 1'b0; bus4.op = OP_MULTU;
    bus4.op_a = '0; bus4.op_b = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset busy", bus1.busy, 0);
    check("reset done", bus1.done, 0);
    check("reset dbz", bus1.div_by_zero, 0);
    check("reset hi", bus1.hi, 0);
    check("reset lo", bus1.lo, 0);

    // MTHI / MTLO: one-edge visibility, never busy, no done.
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    check("mthi hi", bus1.hi, 32'h1234_5678);
    check("mthi busy", bus1.busy, 0);
    check("mthi done", bus1.done, 0);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    check("mtlo lo", bus1.lo, 32'h9ABC_DEF0);
    check("mtlo hi kept", bus1.hi, 32'h1234_5678);

    // MULTU max x max; then done must drop after one cycle.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    check("multu busy after accept", bus1.busy, 1);
    wait_done(33, 0, 0, "multu max");
    tick();
    check("multu done pulse width", bus1.done, 0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done(33, 0, 0, "mult signed");

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done(33, 0, 0, "div -7/2");

    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    expect_result(32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    wait_done(33, 0, 0, "divu");

    issue(OP_DIVU, 32'd5, 32'd0);
    expect_result(32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_done(33, 0, 0, "divu by zero");
    check("div0 done coincident", bus1.done, 1);
    tick();
    check("div0 dbz pulse width", bus1.div_by_zero, 0);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_result(32'h0, 32'h8000_0000, 1'b0);
    wait_done(33, 0, 0, "div overflow");

    // start while busy (an MTHI) must be dropped.
    issue(OP_MULTU, 32'd3, 32'd5);
    expect_result(32'h0, 32'd15, 1'b0);
    repeat (5) tick();
    bus1.start = 1'b1; bus1.op = OP_MTHI; bus1.op_a = 32'hDEAD_BEEF;
    tick();
    bus1.start = 1'b0;
    wait_done(27, 0, 0, "start while busy");

    // clock_enable low for 5 cycles mid-divide delays done by exactly 5.
    issue(OP_DIVU, 32'd100, 32'd7);
    expect_result(32'd2, 32'd14, 1'b0);
    wait_done(38, 10, 5, "ce stall div");

    // Reset 10 cycles into a MULT: result discarded, no done.
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", bus1.busy, 0);
    check("midreset hi", bus1.hi, 0);
    check("midreset lo", bus1.lo, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus1.done) seen = 1'b1;
      tick();
    end
    check("midreset no done", seen, 0);

    // Back-to-back: second MULTU issued in the first one's done cycle.
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    expect_result(32'h1, 32'h0, 1'b0);
    wait_done(33, 0, 0, "b2b first");
    issue(OP_MULTU, 32'd6, 32'd7);
    expect_result(32'h0, 32'd42, 1'b0);
    check("b2b accepted", bus1.busy, 1);
    wait_done(33, 0, 0, "b2b second");

    // A few random operations against the reference model.
    for (int i = 0; i < 4; i++) begin
      op_e         rop;
      logic [31:0] ra, rb;
      rop = op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      sb_q.push_back(model(rop, ra, rb));
      issue(rop, ra, rb);
      wait_done(33, 0, 0, "random");
    end

    // UNROLL=4 instance: same signed product, latency ITER+1 = 9.
    bus4.start = 1'b1; bus4.op = OP_MULT;
    bus4.op_a = 32'hFFFF_FFFD; bus4.op_b = 32'd7;
    tick();
    bus4.start = 1'b0; bus4.op_a = $urandom; bus4.op_b = $urandom;
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    k = 0; seen = 1'b0;
    while (k < 50 && !seen) begin
      tick();
      k++;
      if (bus4.done) seen = 1'b1;
    end
    check("unroll4 done seen", seen, 1);
    check("unroll4 latency", k, 9);
    check("unroll4 scoreboard depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("unroll4 hi", bus4.hi, e.hi);
      check("unroll4 lo", bus4.lo, e.lo);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
